// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin sharing of one pipelined 8x8 multiplier between
// N_REQ requesters, with tagged result return and a drain/halt sequencer.
module mul_share_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_a_i,
  input  logic [8*N_REQ-1:0]   req_b_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [7:0]           mul_a_o,
  output logic [7:0]           mul_b_o,
  input  logic [15:0]          mul_product_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  output logic [16*N_REQ-1:0]  rsp_product_o,
  input  logic [N_REQ-1:0]     rsp_ack_i,
  input  logic                 drain_i,
  output logic                 idle_o,
  output logic [CNT_W-1:0]     issue_cnt_o
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e                   state_q;
  logic                     idle_q;
  logic [ID_W-1:0]          rr_q;
  logic [ID_W-1:0]          rr_d;
  logic [7:0]               mul_a_q;
  logic [7:0]               mul_b_q;
  logic [CNT_W-1:0]         issue_cnt_q;
  logic [MUL_LAT-1:0]       tag_vld_q;
  logic [ID_W-1:0]          tag_id_q [MUL_LAT];
  logic [N_REQ-1:0]         rsp_valid_q;
  logic [N_REQ-1:0][15:0]   rsp_product_q;

  logic [N_REQ-1:0][7:0]    req_a_v;
  logic [N_REQ-1:0][7:0]    req_b_v;
  logic [N_REQ-1:0]         busy;
  logic [N_REQ-1:0]         elig;
  logic [N_REQ-1:0]         gnt;
  logic [ID_W-1:0]          gnt_id;
  logic [ID_W-1:0]          arb_id;
  logic                     gnt_found;
  logic                     hs;
  logic                     run_ok;
  logic                     pipe_empty;

  assign req_a_v = req_a_i;
  assign req_b_v = req_b_i;

  // Grants only in RUN with drain low; reset also forces the grant low.
  assign run_ok     = (state_q == ST_RUN) & ~drain_i & ~rst;
  assign elig       = req_valid_i & ~busy & {N_REQ{run_ok}};
  assign hs         = gnt_found;
  assign pipe_empty = ~|tag_vld_q;

  // A requester is busy while its tag is in flight or its result is unacked.
  always_comb begin
    busy = rsp_valid_q;
    for (int unsigned s = 0; s < MUL_LAT; s++) begin
      if (tag_vld_q[s]) busy[tag_id_q[s]] = 1'b1;
    end
  end

  // Round-robin search upward from the pointer, first eligible wins.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    arb_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      arb_id = ID_W'((32'(rr_q) + k) % N_REQ);
      if (!gnt_found && elig[arb_id]) begin
        gnt_found   = 1'b1;
        gnt[arb_id] = 1'b1;
        gnt_id      = arb_id;
      end
    end
  end

  // Pointer advances past the winner only on a handshake.
  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + ID_W'(1);
  end

  // Operand registers, pointer and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      issue_cnt_q <= '0;
    end else begin
      rr_q <= rr_d;
      if (hs) begin
        mul_a_q     <= req_a_v[gnt_id];
        mul_b_q     <= req_b_v[gnt_id];
        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      end
    end
  end

  // Tag pipe tracks which requester owns each multiplier stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned s = 0; s < MUL_LAT; s++) tag_id_q[s] <= '0;
    end else begin
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= gnt_id;
      for (int unsigned s = 1; s < MUL_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  // Capture products for the tagged owner; hold until acknowledged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (rsp_ack_i[i] && rsp_valid_q[i]) rsp_valid_q[i] <= 1'b0;
      end
      if (tag_vld_q[MUL_LAT-1]) begin
        rsp_valid_q[tag_id_q[MUL_LAT-1]]   <= 1'b1;
        rsp_product_q[tag_id_q[MUL_LAT-1]] <= mul_product_i;
      end
    end
  end

  // Drain sequencer: stop granting, wait for an empty pipe, park in HALT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (drain_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pipe_empty) begin
            state_q <= ST_HALT;
            idle_q  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!drain_i) begin
            state_q <= ST_RUN;
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = gnt;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_product_o = rsp_product_q;
  assign idle_o        = idle_q;
  assign issue_cnt_o   = issue_cnt_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// Bench for mul_share_sched: arbitration table, hand-written corner sequences,
// randomized traffic against a queue-based reference model, counter wrap.
module tb_mul_share_sched;

  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 2;
  localparam int CNT_W   = 16;
  localparam int MODE_RUN = 0, MODE_DRAIN = 1, MODE_HALT = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid;
  logic [8*N_REQ-1:0]  req_a;
  logic [8*N_REQ-1:0]  req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [7:0]          mul_a;
  logic [7:0]          mul_b;
  logic [15:0]         mul_product;
  logic [N_REQ-1:0]    rsp_valid;
  logic [16*N_REQ-1:0] rsp_product;
  logic [N_REQ-1:0]    rsp_ack;
  logic                drain;
  logic                idle;
  logic [CNT_W-1:0]    issue_cnt;

  always #5 clk = ~clk;

  mul_share_sched #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_product_i(mul_product),
    .rsp_valid_o(rsp_valid), .rsp_product_o(rsp_product), .rsp_ack_i(rsp_ack),
    .drain_i(drain), .idle_o(idle), .issue_cnt_o(issue_cnt)
  );

  // Exact multiplier: mul_a/mul_b form the first stage, this register the second.
  logic [15:0] stub_q;
  always @(posedge clk) stub_q <= {8'h00, mul_a} * {8'h00, mul_b};
  assign mul_product = stub_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_a = '0; req_b = '0; rsp_ack = '0; drain = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct { int id; logic [15:0] prod; int arrive; } flight_t;
  flight_t          m_fl[$];
  int               m_mode, m_rr, m_cyc;
  logic [N_REQ-1:0] m_rsp_v;
  logic [15:0]      m_rsp_p [N_REQ];
  logic [15:0]      m_cnt;
  logic [7:0]       m_mul_a, m_mul_b;

  task automatic model_reset();
    m_fl.delete();
    m_mode = MODE_RUN; m_rr = 0; m_cyc = 0;
    m_rsp_v = '0; m_cnt = '0; m_mul_a = '0; m_mul_b = '0;
    for (int i = 0; i < N_REQ; i++) m_rsp_p[i] = '0;
  endtask

  function automatic bit model_busy(input int i);
    if (m_rsp_v[i]) return 1'b1;
    foreach (m_fl[j]) if (m_fl[j].id == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_grant(input logic [N_REQ-1:0] v, input logic d);
    if (m_mode != MODE_RUN || d) return -1;
    for (int k = 0; k < N_REQ; k++) begin
      int i = (m_rr + k) % N_REQ;
      if (v[i] && !model_busy(i)) return i;
    end
    return -1;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step(input int g);
    bit empty = (m_fl.size() == 0);
    flight_t f;
    for (int i = 0; i < N_REQ; i++) if (rsp_ack[i] && m_rsp_v[i]) m_rsp_v[i] = 1'b0;
    if (g >= 0) begin
      m_mul_a  = req_a[8*g +: 8];
      m_mul_b  = req_b[8*g +: 8];
      f.id     = g;
      f.prod   = 16'(m_mul_a) * 16'(m_mul_b);
      f.arrive = m_cyc + 1 + MUL_LAT;
      m_fl.push_back(f);
      m_rr  = (g + 1) % N_REQ;
      m_cnt = m_cnt + 16'd1;
    end
    case (m_mode)
      MODE_RUN:   if (drain) m_mode = MODE_DRAIN;
      MODE_DRAIN: if (empty) m_mode = MODE_HALT;
      default:    if (!drain) m_mode = MODE_RUN;
    endcase
    m_cyc++;
    for (int j = m_fl.size() - 1; j >= 0; j--) begin
      if (m_fl[j].arrive == m_cyc) begin
        m_rsp_v[m_fl[j].id] = 1'b1;
        m_rsp_p[m_fl[j].id] = m_fl[j].prod;
        m_fl.delete(j);
      end
    end
  endtask

  // ---------------- arbitration table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_mul_a;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t tbl [9];

  logic [63:0] exp_prod;
  logic [3:0]  exp_ready;
  int          g;
  bit          drain_r;

  initial begin
    // requester i: a=0x10+i, b=0x20+i; always acking; hand-derived outcomes
    tbl[0] = '{4'b0000, 4'b0000, 8'h00, 16'd0};
    tbl[1] = '{4'b1010, 4'b0010, 8'h11, 16'd1};
    tbl[2] = '{4'b1010, 4'b1000, 8'h13, 16'd2};
    tbl[3] = '{4'b1111, 4'b0001, 8'h10, 16'd3};
    tbl[4] = '{4'b1111, 4'b0100, 8'h12, 16'd4};
    tbl[5] = '{4'b1111, 4'b0010, 8'h11, 16'd5};
    tbl[6] = '{4'b0001, 4'b0000, 8'h11, 16'd5};
    tbl[7] = '{4'b0001, 4'b0001, 8'h10, 16'd6};
    tbl[8] = '{4'b0000, 4'b0000, 8'h10, 16'd6};

    clear_inputs();

    // Reset state, with requests asserted during reset
    rst = 1'b1;
    req_valid = '1;
    repeat (2) tick();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_mul_a", 64'(mul_a), 64'h0);
    chk("rst_mul_b", 64'(mul_b), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_product", 64'(rsp_product), 64'h0);
    chk("rst_idle", 64'(idle), 64'h0);
    chk("rst_issue_cnt", 64'(issue_cnt), 64'h0);

    // Table-driven arbitration sequence
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[8*i +: 8] = 8'(8'h10 + i);
      req_b[8*i +: 8] = 8'(8'h20 + i);
    end
    rsp_ack = '1;
    for (int r = 0; r < 9; r++) begin
      req_valid = tbl[r].valid;
      #1;
      chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
      tick();
      chk($sformatf("tbl%0d_mul_a", r), 64'(mul_a), 64'(tbl[r].exp_mul_a));
      chk($sformatf("tbl%0d_cnt", r), 64'(issue_cnt), 64'(tbl[r].exp_cnt));
    end

    // Single request, latency, and hold-until-ack with re-grant timing
    do_reset();
    req_valid = 4'b0100; req_a[23:16] = 8'h0F; req_b[23:16] = 8'h03;
    #1 chk("t1_ready", 64'(req_ready), 64'h4);
    tick();
    chk("t1_mul_a", 64'(mul_a), 64'h0F);
    chk("t1_mul_b", 64'(mul_b), 64'h03);
    req_valid = '0;
    tick();
    chk("t1_rsp_early", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("t1_rsp_product", 64'(rsp_product[47:32]), 64'h002D);
    req_valid = 4'b0100; req_a[23:16] = 8'h05; req_b[23:16] = 8'h07;
    #1 chk("t3_ready_busy", 64'(req_ready), 64'h0);
    tick();
    chk("t3_rsp_hold", 64'(rsp_valid), 64'h4);
    chk("t3_prod_hold", 64'(rsp_product[47:32]), 64'h002D);
    rsp_ack = 4'b0100;
    #1 chk("t3_ready_ack_cycle", 64'(req_ready), 64'h0);
    tick();
    rsp_ack = '0;
    chk("t3_rsp_cleared", 64'(rsp_valid), 64'h0);
    #1 chk("t3_regrant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    chk("t3_mul_a", 64'(mul_a), 64'h05);
    repeat (2) tick();
    chk("t3_rsp2_valid", 64'(rsp_valid), 64'h4);
    chk("t3_rsp2_product", 64'(rsp_product[47:32]), 64'h0023);
    rsp_ack = 4'b0100;
    tick();
    rsp_ack = '0;

    // All four requesters at once, acked on arrival
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[8*i +: 8] = 8'(i + 2);
      req_b[8*i +: 8] = 8'(i + 3);
    end
    rsp_ack = '1;
    for (int c = 0; c < 7; c++) begin
      if (c >= 3) begin
        chk($sformatf("t2_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(1 << (c - 3)));
        exp_prod = 64'((c - 1) * c);
        chk($sformatf("t2_rsp_prod_c%0d", c), 64'(rsp_product[16*(c-3) +: 16]), exp_prod);
      end else begin
        chk($sformatf("t2_rsp_valid_c%0d", c), 64'(rsp_valid), 64'h0);
      end
      req_valid = (c < 4) ? 4'b1111 : 4'b0000;
      #1 chk($sformatf("t2_ready_c%0d", c), 64'(req_ready), (c < 4) ? 64'(1 << c) : 64'h0);
      tick();
    end
    chk("t2_issue_cnt", 64'(issue_cnt), 64'd4);

    // Drain: blocked grant, HALT after pipe empties, resume on release
    do_reset();
    rsp_ack = '1;
    req_valid = 4'b0001;
    #1 chk("t4_ready_c0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0010; drain = 1'b1;
    #1 chk("t4_ready_c1", 64'(req_ready), 64'h0);
    tick();
    chk("t4_idle_c2", 64'(idle), 64'h0);
    tick();
    chk("t4_idle_c3", 64'(idle), 64'h0);
    tick();
    chk("t4_idle_c4", 64'(idle), 64'h1);
    drain = 1'b0;
    #1 chk("t4_ready_halt", 64'(req_ready), 64'h0);
    tick();
    chk("t4_idle_c5", 64'(idle), 64'h0);
    #1 chk("t4_ready_resume", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset while a product is in flight
    do_reset();
    rsp_ack = '1;
    req_valid = 4'b1000; req_a[31:24] = 8'hFF; req_b[31:24] = 8'hFF;
    #1 chk("t5_ready", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    chk("t5_mul_a", 64'(mul_a), 64'hFF);
    rst = 1'b1;
    #1;
    chk("t5_rst_mul_a", 64'(mul_a), 64'h0);
    chk("t5_rst_mul_b", 64'(mul_b), 64'h0);
    chk("t5_rst_cnt", 64'(issue_cnt), 64'h0);
    chk("t5_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t5_rst_idle", 64'(idle), 64'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t5_no_rsp_%0d", c), 64'(rsp_valid), 64'h0);
    end
    req_valid = 4'b1000; req_a[31:24] = 8'h12; req_b[31:24] = 8'h34;
    #1 chk("t5_ready_again", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    repeat (2) tick();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h8);
    chk("t5_rsp_product", 64'(rsp_product[63:48]), 64'h03A8);
    chk("t5_issue_cnt", 64'(issue_cnt), 64'd1);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    drain_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      exp_prod = '0;
      for (int i = 0; i < N_REQ; i++) exp_prod[16*i +: 16] = m_rsp_p[i];
      chk("rnd_rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
      chk("rnd_rsp_product", 64'(rsp_product), exp_prod);
      chk("rnd_idle", 64'(idle), 64'(m_mode == MODE_HALT));
      chk("rnd_issue_cnt", 64'(issue_cnt), 64'(m_cnt));
      chk("rnd_mul_a", 64'(mul_a), 64'(m_mul_a));
      chk("rnd_mul_b", 64'(mul_b), 64'(m_mul_b));
      req_valid = 4'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      rsp_ack   = 4'($urandom);
      if ($urandom_range(0, 24) == 0) drain_r = ~drain_r;
      drain = drain_r;
      #1;
      g = model_grant(req_valid, drain);
      exp_ready = (g < 0) ? 4'b0000 : 4'(1 << g);
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
      model_step(g);
      tick();
    end

    // Counter wrap: saturated traffic grants one request per cycle
    do_reset();
    req_valid = '1; rsp_ack = '1;
    repeat (65535) tick();
    chk("t6_cnt_max", 64'(issue_cnt), 64'hFFFF);
    tick();
    chk("t6_cnt_wrap", 64'(issue_cnt), 64'h0000);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
